// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    // Generator top count; one generator period is PWM_TOP+1 clk cycles.
    localparam int unsigned PWM_TOP = 5000;

endpackage

// File: rtl/pwm_cap_sync.sv
// Input conditioning for pwm_capture: 2-flop synchroniser, optional glitch
// filter (PWM_CAP_GLITCH_FILTER_EN) and registered rise/fall edge detector.
module pwm_cap_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic sync_a;
    logic sync_b;
    logic lvl_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= pwm_in;
            sync_b <= sync_a;
        end
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    // Counter runs 0..FILT_LEN-1 while the synchronised input disagrees with lvl.
    localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    logic [FW-1:0] filt_cnt;
    logic          filt_lvl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_lvl <= 1'b0;
        end else if (sync_b == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            filt_lvl <= sync_b;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync_b;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            lvl_d <= lvl;
            rise  <= lvl & ~lvl_d;
            fall  <= ~lvl & lvl_d;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM duty/period measurement in clk cycles with saturation (stuck) detection.
// Optional input glitch filter enabled by defining PWM_CAP_GLITCH_FILTER_EN.
//
// state  | meaning
// S_IDLE | disarmed; waiting for a rising edge to start measuring
// S_HIGH | input high; hi_cnt and per_cnt running
// S_LOW  | input low; per_cnt running, hi_cnt frozen
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic lvl;
    logic rise;
    logic fall;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] hi_nx;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] per_nx;
    logic [CNT_W-1:0] duty_nx;
    logic [CNT_W-1:0] period_nx;
    logic             valid_nx;
    logic             stuck_nx;

    pwm_cap_sync #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .lvl    (lvl),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            hi_cnt  <= '0;
            per_cnt <= '0;
            duty    <= '0;
            period  <= '0;
            valid   <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            state   <= state_nx;
            hi_cnt  <= hi_nx;
            per_cnt <= per_nx;
            duty    <= duty_nx;
            period  <= period_nx;
            valid   <= valid_nx;
            stuck   <= stuck_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        hi_nx     = hi_cnt;
        per_nx    = per_cnt;
        duty_nx   = duty;
        period_nx = period;
        valid_nx  = 1'b0;
        stuck_nx  = stuck;

        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nx = S_HIGH;
                    hi_nx    = CNT_ONE;
                    per_nx   = CNT_ONE;
                    stuck_nx = 1'b0;
                end
            end

            S_HIGH: begin
                // Saturation wins over any edge arriving in the same cycle.
                if (per_cnt == CNT_MAX) begin
                    state_nx  = S_IDLE;
                    valid_nx  = 1'b1;
                    period_nx = CNT_MAX;
                    duty_nx   = lvl ? CNT_MAX : '0;
                    stuck_nx  = 1'b1;
                end else if (fall) begin
                    state_nx = S_LOW;
                    per_nx   = per_cnt + 1'b1;
                end else begin
                    hi_nx  = hi_cnt + 1'b1;
                    per_nx = per_cnt + 1'b1;
                end
            end

            S_LOW: begin
                if (per_cnt == CNT_MAX) begin
                    state_nx  = S_IDLE;
                    valid_nx  = 1'b1;
                    period_nx = CNT_MAX;
                    duty_nx   = lvl ? CNT_MAX : '0;
                    stuck_nx  = 1'b1;
                end else if (rise) begin
                    state_nx  = S_HIGH;
                    duty_nx   = hi_cnt;
                    period_nx = per_cnt;
                    valid_nx  = 1'b1;
                    hi_nx     = CNT_ONE;
                    per_nx    = CNT_ONE;
                end else begin
                    per_nx = per_cnt + 1'b1;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the duty and period counters and outputs.
REQ-002 SHALL have parameter FILT_LEN, default 3: glitch-filter stability length in clk cycles (used only when PWM_CAP_GLITCH_FILTER_EN is defined).
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port pwm_in, input, 1: asynchronous PWM waveform to be measured.
REQ-006 SHALL have port duty, output, CNT_W: high time of the last complete period, in clk cycles.
REQ-007 SHALL have port period, output, CNT_W: length of the last complete period (rising edge to rising edge), in clk cycles.
REQ-008 SHALL have port valid, output, 1: one-cycle strobe when duty and period update.
REQ-009 SHALL have port stuck, output, 1: level flag, asserted when no edge is seen within counter range.

Function
REQ-010 SHALL pass pwm_in through a 2-flop synchroniser; the synchronised (and optionally filtered) level is "lvl"; edges are detected by comparing lvl with its one-cycle-delayed copy.
REQ-011 SHALL implement FSM states S_IDLE, S_HIGH, S_LOW.
REQ-012 S_IDLE: wait for a rising edge; on the edge go to S_HIGH, set hi_cnt=1 and per_cnt=1, emit no valid, and clear stuck.
REQ-013 S_HIGH: increment hi_cnt and per_cnt each cycle; on a falling edge go to S_LOW, freeze hi_cnt, and increment per_cnt.
REQ-014 S_LOW: increment per_cnt each cycle; on a rising edge latch duty=hi_cnt and period=per_cnt, pulse valid in the next cycle, restart hi_cnt=1 and per_cnt=1, and go to S_HIGH.
REQ-015 For an ideal input high H cycles and low L cycles, each complete period SHALL report duty=H and period=H+L exactly.
REQ-016 duty and period SHALL be registered and SHALL hold their value between valid strobes.
REQ-017 Saturation: if per_cnt reaches 2^CNT_W-1 in S_HIGH or S_LOW, the block SHALL pulse valid with period=2^CNT_W-1, set duty=2^CNT_W-1 if lvl=1 or 0 if lvl=0, set stuck=1, and go to S_IDLE.
REQ-018 In S_IDLE, no counter SHALL run and stuck SHALL hold its value.
REQ-019 Latency from a pwm_in rising edge to valid SHALL be 4 clk cycles without the filter and 4+FILT_LEN clk cycles with it.
REQ-020 The first rising edge after reset or after a stuck event SHALL only arm the measurement; it SHALL NOT produce a valid strobe.

Reset
REQ-021 When rst_n=0 at a clk edge: FSM goes to S_IDLE; duty=0, period=0, valid=0, stuck=0; synchroniser, filter and counters are cleared to 0.
REQ-022 Reset during a measurement SHALL discard the partial measurement; the next valid SHALL require a fresh arming edge plus one full period.

Configuration
REQ-023 With PWM_CAP_GLITCH_FILTER_EN defined, lvl SHALL change only after the synchronised input has held the new value for FILT_LEN consecutive cycles; pulses shorter than FILT_LEN SHALL be ignored; the measured H and L SHALL be unchanged for pulses of at least FILT_LEN.
REQ-024 Without PWM_CAP_GLITCH_FILTER_EN, lvl SHALL equal the synchroniser output and FILT_LEN SHALL be unused.

Structure
REQ-025 Shared package pwm_pkg SHALL hold the FSM state enum (S_IDLE, S_HIGH, S_LOW) and constant PWM_TOP=5000 (generator top count; the generator period is PWM_TOP+1 = 5001 cycles).
REQ-026 Sub-module pwm_cap_sync SHALL contain the synchroniser, the optional filter and the edge detector, and SHALL output lvl, rise and fall.

Verification
REQ-027 Reset, then 3 periods with H=2500, L=2501: the bench SHALL see no valid on the first period, then valid with duty=2500, period=5001 for each later period.
REQ-028 H=4997, L=4 followed by H=178, L=4823: the bench SHALL see successive valids with (4997,5001) then (178,5001).
REQ-029 pwm_in held low for 70000 cycles after arming: the bench SHALL see exactly one valid with duty=0, period=65535, stuck=1; the next rising edge SHALL clear stuck with no valid.
REQ-030 Assert rst_n=0 for one cycle during S_LOW: the bench SHALL see all outputs at 0, no valid for the interrupted period, and a correct valid after re-arming plus one full period.
REQ-031 With PWM_CAP_GLITCH_FILTER_EN and FILT_LEN=3, a 2-cycle low glitch inside a 2500-cycle high phase: the bench SHALL see duty=2500 and period=5001 unaffected; without the macro, the bench SHALL see an extra short measurement.
